// File: rtl/uart_rx_frontend.sv
// UART receive front-end: synchronises the rx pad, qualifies start bits, majority-samples
// each bit at mid-period and hands good bytes to the FIFO over a valid/ready handshake.
module uart_rx_frontend #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          clk_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic [1:0]             state_reg, state_next;
    logic [31:0]            cnt_reg, cnt_next;
    logic [31:0]            div_reg, div_next;
    logic [31:0]            bit_idx_reg, bit_idx_next;
    logic [1:0]             samp_reg, samp_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   valid_reg, valid_next;
    logic                   ferr_reg, ferr_next;
    logic                   ovr_reg, ovr_next;

    logic        rx_s;
    logic        fall;
    logic        at_decide;
    logic        at_end;
    logic        majority;
    logic [31:0] div_cap;
    logic [31:0] half;

    assign rx_s      = sync_reg[SYNC_STAGES-1];
    assign fall      = ~rx_s & rx_prev_reg;
    assign div_cap   = (clk_div < 32'd4) ? 32'd4 : clk_div;
    assign half      = div_reg >> 1;
    assign at_decide = (cnt_reg == half + 32'd1);
    assign at_end    = (cnt_reg == div_reg - 32'd1);
    // Third vote is the live sample taken in the decision cycle itself.
    assign majority  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

    assign o_data      = data_reg;
    assign o_valid     = valid_reg;
    assign o_frame_err = ferr_reg;
    assign o_overrun   = ovr_reg;
    assign o_busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 32'd1;
        div_next     = div_reg;
        bit_idx_next = bit_idx_reg;
        samp_next    = samp_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = valid_reg & ~i_ready;
        ferr_next    = 1'b0;
        ovr_next     = 1'b0;

        if (cnt_reg == half - 32'd1) begin
            samp_next[0] = rx_s;
        end
        if (cnt_reg == half) begin
            samp_next[1] = rx_s;
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next = 32'd0;
                if (fall) begin
                    state_next = ST_START;
                    div_next   = div_cap;
                end
            end
            ST_START: begin
                if (at_decide && majority) begin
                    state_next = ST_IDLE;
                    cnt_next   = 32'd0;
                end else if (at_end) begin
                    state_next   = ST_DATA;
                    cnt_next     = 32'd0;
                    bit_idx_next = 32'd0;
                end
            end
            ST_DATA: begin
                if (at_decide) begin
                    shift_next = {majority, shift_reg[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    cnt_next = 32'd0;
                    if (bit_idx_reg == 32'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 32'd1;
                    end
                end
            end
            default: begin
                if (at_decide) begin
                    cnt_next = 32'd0;
                    if (majority) begin
                        if (!valid_reg || i_ready) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        ferr_next = 1'b1;
                    end
                    // At the minimum divisor the next start edge lands in this very cycle.
                    if (fall) begin
                        state_next = ST_START;
                        div_next   = div_cap;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            cnt_reg     <= 32'd0;
            div_reg     <= 32'd4;
            bit_idx_reg <= 32'd0;
            samp_reg    <= 2'b00;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= rx_s;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            samp_reg    <= samp_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            ovr_reg     <= ovr_next;
        end
    end

endmodule
